// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the RV32M divide unit.
//   div_op_t    - divide operation encoding (also used by the ALU's ALUM decode)
//   div_state_t - divider FSM state, exported for debug/observation
//   XLEN        - operand/result width
//   DIV_STEPS   - number of restoring iterations per divide
//   negate()    - two's-complement negation helper
package div_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_STEPS = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return '0 - x;
    endfunction

endpackage

// File: rtl/div_if.sv
// div_if: request/response bundle between the execute stage and div_unit.
//   master (execute stage): drives start, flush, op, dividend, divisor;
//                           observes busy, valid, result.
//   slave  (div_unit)     : the mirror image.
//
// Handshake: the requester holds start high (with stable op/operands) for as
// long as the divide instruction sits in execute. The request is taken on a
// rising edge where the unit is idle, start=1 and flush=0. busy is high while
// iterating; valid is a single-cycle pulse marking the one cycle in which
// result belongs to that request. There is no backpressure on valid: the
// requester must consume result in the valid cycle. flush cancels the
// request in flight, including a valid that would otherwise appear in that
// same cycle.
interface div_if;
    import div_pkg::*;

    logic            start;
    logic            flush;
    div_op_t         op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, op, dividend, divisor,
        input  busy, valid, result
    );

    modport slave (
        input  start, flush, op, dividend, divisor,
        output busy, valid, result
    );

endinterface

// File: rtl/div_step.sv
// div_step: one restoring shift/subtract iteration (combinational).
//   rem_in  [XLEN:0]   - partial remainder R
//   quo_in  [XLEN-1:0] - quotient/dividend shift register Q
//   divisor [XLEN-1:0] - divisor magnitude
//   rem_out, quo_out   - R and Q after this step
module div_step
    import div_pkg::*;
(
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [2*XLEN:0] shifted;
    logic [XLEN+1:0] trial;

    always_comb begin
        shifted = {rem_in, quo_in} << 1;
        // One extra bit on the subtraction so its MSB is the borrow/sign.
        trial   = {1'b0, shifted[2*XLEN:XLEN]} - {2'b00, divisor};
        if (!trial[XLEN+1]) begin
            rem_out = trial[XLEN:0];
            quo_out = {shifted[XLEN-1:1], 1'b1};
        end else begin
            rem_out = shifted[2*XLEN:XLEN];
            quo_out = shifted[XLEN-1:0];
        end
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//   clk       - rising-edge clock
//   reset     - synchronous, active-low
//   bus       - div_if.slave: start/flush/op/dividend/divisor in,
//               busy/valid/result out
//   state_dbg - current FSM state, for observation only
// Normal latency is 33 cycles from the accept edge to valid; divide-by-zero
// and signed overflow finish in 1 cycle without iterating.
module div_unit
    import div_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    div_if.slave       bus,
    output div_state_t state_dbg
);

    div_state_t      state, state_next;
    logic [5:0]      count;
    div_op_t         op_q;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] quo_q, dvs_q, result_q;
    logic            neg_quo_q, neg_rem_q;

    logic            is_signed, is_rem, a_neg, b_neg;
    logic            div_zero, overflow, special, last_step;
    logic [XLEN-1:0] a_mag, b_mag, special_result;
    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo, fin_quo, fin_rem;
    logic            busy, valid;

    // Request decode, only meaningful in IDLE.
    assign is_signed = (bus.op == DIV) || (bus.op == REM);
    assign is_rem    = (bus.op == REM) || (bus.op == REMU);
    assign a_neg     = is_signed && bus.dividend[XLEN-1];
    assign b_neg     = is_signed && bus.divisor[XLEN-1];
    // |-2^31| wraps to 0x8000_0000, which is correct read as unsigned.
    assign a_mag     = a_neg ? negate(bus.dividend) : bus.dividend;
    assign b_mag     = b_neg ? negate(bus.divisor) : bus.divisor;
    assign div_zero  = (bus.divisor == '0);
    assign overflow  = is_signed && (bus.dividend == {1'b1, {(XLEN-1){1'b0}}})
                       && (bus.divisor == '1);
    assign special   = div_zero || overflow;

    always_comb begin
        special_result = '0;
        if (div_zero)
            special_result = is_rem ? bus.dividend : '1;
        else if (overflow)
            special_result = is_rem ? '0 : bus.dividend;
    end

    div_step u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Sign fixup on the outcome of the final step, registered on DONE entry.
    assign fin_quo   = neg_quo_q ? negate(step_quo) : step_quo;
    assign fin_rem   = neg_rem_q ? negate(step_rem[XLEN-1:0]) : step_rem[XLEN-1:0];
    assign last_step = (state == CALC) && (count == 6'(DIV_STEPS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_next = special ? DONE : CALC;
                CALC:    if (last_step) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs. A flush arriving in DONE cancels that cycle's valid.
    always_comb begin
        busy  = (state == CALC);
        valid = (state == DONE) && !bus.flush;
    end

    // Datapath and iteration counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count     <= '0;
            op_q      <= DIV;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (bus.flush) begin
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q      <= bus.op;
                        count     <= '0;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (special) begin
                            result_q <= special_result;
                        end else begin
                            rem_q <= '0;
                            quo_q <= a_mag;
                            dvs_q <= b_mag;
                        end
                    end
                end
                CALC: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    count <= count + 6'd1;
                    if (last_step)
                        result_q <= ((op_q == REM) || (op_q == REMU)) ? fin_rem : fin_quo;
                end
                default: count <= '0;
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.valid  = valid;
    assign bus.result = result_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed-vector bench for div_unit with an expected-result queue.
module tb_div_unit;
    import div_pkg::*;

    logic       clk;
    logic       reset;
    div_state_t state_dbg;

    div_if bus ();

    div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_ops    = 0;
    int valid_cnt = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (bus.valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(bus.valid), 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("result", bus.result, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one divide, hold start until the edge that closes DONE, then drop it.
    task automatic run_op(input div_op_t o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int exp_lat);
        int lat;
        int busy_n;
        exp_q.push_back(exp_r);
        n_ops++;
        bus.op       = o;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        lat    = 0;
        busy_n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_n++;
            if (bus.valid) break;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_cycles", 32'(busy_n), 32'(exp_lat - 1));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        bus.op       = DIVU;
        bus.dividend = '0;
        bus.divisor  = '0;
        idle(3);
        check("rst_busy",   32'(bus.busy),  32'd0);
        check("rst_valid",  32'(bus.valid), 32'd0);
        check("rst_result", bus.result,     32'd0);
        check("rst_state",  32'(state_dbg), 32'(IDLE));
        reset = 1'b1;
        idle(2);

        // Iterative path
        run_op(DIVU, 32'd100,       32'd7,          32'd14,         33); idle(2);
        run_op(DIV,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33); idle(2);
        run_op(REM,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33); idle(2);
        run_op(REMU, 32'hFFFF_FFF9, 32'd2,          32'd1,          33); idle(2);
        run_op(DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33); idle(2);
        run_op(REM,  32'd7,         32'hFFFF_FFFE, 32'd1,          33); idle(2);
        run_op(DIV,  32'h8000_0000, 32'd2,          32'hC000_0000, 33); idle(2);
        run_op(DIVU, 32'h8000_0000, 32'd2,          32'h4000_0000, 33); idle(2);

        // Special cases
        run_op(DIV,  32'h0000_1234, 32'd0,          32'hFFFF_FFFF, 1); idle(2);
        run_op(REM,  32'h0000_1234, 32'd0,          32'h0000_1234, 1); idle(2);
        run_op(DIVU, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF, 1); idle(2);
        run_op(REMU, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 1); idle(2);
        run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); idle(2);
        run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          1); idle(2);

        // Back-to-back: second start lands in the IDLE cycle right after DONE
        run_op(DIVU, 32'd10, 32'd3, 32'd3, 33);
        run_op(DIVU, 32'd20, 32'd6, 32'd3, 33);
        idle(40);

        // Flush mid-CALC: no valid must ever appear for this one
        bus.op = DIVU; bus.dividend = 32'd1000; bus.divisor = 32'd7; bus.start = 1'b1;
        @(posedge clk);
        idle(10);
        check("pre_flush_busy", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("flush_busy",  32'(bus.busy),  32'd0);
        check("flush_state", 32'(state_dbg), 32'(IDLE));
        bus.flush = 1'b0;
        idle(40);
        run_op(DIVU, 32'd9, 32'd3, 32'd3, 33); idle(2);

        // Flush in the DONE cycle of a special case suppresses valid
        bus.op = DIVU; bus.dividend = 32'h55; bus.divisor = 32'd0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("done_flush_state", 32'(state_dbg), 32'(DONE));
        check("done_flush_valid", 32'(bus.valid), 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("after_done_flush_state", 32'(state_dbg), 32'(IDLE));
        idle(3);

        // start together with flush in IDLE is not accepted
        bus.op = DIVU; bus.dividend = 32'd5; bus.divisor = 32'd1;
        bus.start = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        check("start_flush_state", 32'(state_dbg), 32'(IDLE));
        check("start_flush_busy",  32'(bus.busy),  32'd0);
        bus.start = 1'b0; bus.flush = 1'b0;
        idle(3);

        // Reset mid-CALC
        bus.op = DIVU; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.start = 1'b1;
        @(posedge clk);
        idle(5);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("midrst_busy",   32'(bus.busy),  32'd0);
        check("midrst_valid",  32'(bus.valid), 32'd0);
        check("midrst_result", bus.result,     32'd0);
        check("midrst_state",  32'(state_dbg), 32'(IDLE));
        reset = 1'b1;
        idle(2);
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        idle(40);

        // Final report
        check("valid_pulses",  32'(valid_cnt),    32'(n_ops));
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog bounding the whole run
    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
